rtc_bcd_core: RTL and testbench

Parametrised real-time-clock core for the digital alarm design. It divides the system clock into one-second ticks and keeps hours, minutes and seconds as six BCD digits. It accepts per-digit time setting with range checking and provides 12/24-hour display conversion. It also compares against a programmable hh:mm alarm and drives a timed ring output. The block sits between the key/setting controller and the seg595 display driver, which consumes `data` and `point` directly.

---
 rtl/rtc_bcd_core.sv | 160 ++++++++++++++++
 tb/tb_rtc_bcd_core.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bcd_core.sv
// BCD real-time clock: one-second divider, hh:mm:ss digits with per-digit setting,
// 12/24-hour display conversion and an hh:mm alarm with a timed ring output.
module rtc_bcd_core #(
  parameter int         TICK_DIV   = 50_000_000,
  parameter int         RING_SECS  = 30,
  parameter logic [5:0] POINT_MASK = 6'b101011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        work_en,
  input  logic        set_flag,
  input  logic [2:0]  set_pos,
  input  logic [3:0]  set_data,
  input  logic        mode_12h,
  input  logic        alarm_wr,
  input  logic [15:0] alarm_data,
  input  logic        alarm_en,
  input  logic        alarm_ack,
  output logic [23:0] data,
  output logic [5:0]  point,
  output logic        pm,
  output logic        sec_pulse,
  output logic        set_err,
  output logic        ring
);

  localparam int                CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  // dig_q[0] = s_l ... dig_q[5] = h_h
  logic [5:0][3:0]  dig_q, dig_d, cand;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      alarm_q, alarm_d;
  logic [7:0]       ring_cnt_q, ring_cnt_d;
  logic             ring_q, ring_d;
  logic [23:0]      data_q, data_d;
  logic             pm_q, pm_d;
  logic             sec_pulse_q, sec_pulse_d;
  logic             set_err_q, set_err_d;
  logic             tick, hit, wr_ok;
  logic [3:0]       lim;
  logic [7:0]       hour;

  function automatic logic [7:0] hour_bin(input logic [3:0] hh, input logic [3:0] hl);
    return ({4'd0, hh} * 8'd10) + {4'd0, hl};
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [7:0] v);
    if (v >= 8'd20)      return {4'd2, 4'(v - 8'd20)};
    else if (v >= 8'd10) return {4'd1, 4'(v - 8'd10)};
    else                 return {4'd0, v[3:0]};
  endfunction

  function automatic logic [7:0] disp_hour(input logic [7:0] h, input logic twelve);
    if (!twelve)     return h;
    if (h == 8'd0)   return 8'd12;
    if (h > 8'd12)   return h - 8'd12;
    return h;
  endfunction

  always_comb begin
    dig_d       = dig_q;
    cand        = dig_q;
    alarm_d     = alarm_q;
    ring_d      = ring_q;
    ring_cnt_d  = ring_cnt_q;
    set_err_d   = 1'b0;
    wr_ok       = 1'b0;
    lim         = 4'd9;
    tick        = work_en && (cnt_q == CNT_MAX);
    cnt_d       = (work_en && !tick) ? cnt_q + CNT_W'(1) : '0;
    sec_pulse_d = tick;

    if (tick) begin
      dig_d[0] = dig_q[0] + 4'd1;
      if (dig_q[0] == 4'd9) begin
        dig_d[0] = 4'd0;
        dig_d[1] = dig_q[1] + 4'd1;
        if (dig_q[1] == 4'd5) begin
          dig_d[1] = 4'd0;
          dig_d[2] = dig_q[2] + 4'd1;
          if (dig_q[2] == 4'd9) begin
            dig_d[2] = 4'd0;
            dig_d[3] = dig_q[3] + 4'd1;
            if (dig_q[3] == 4'd5) begin
              dig_d[3] = 4'd0;
              if (dig_q[5] == 4'd2 && dig_q[4] == 4'd3) begin
                dig_d[5] = 4'd0;
                dig_d[4] = 4'd0;
              end else if (dig_q[4] == 4'd9) begin
                dig_d[4] = 4'd0;
                dig_d[5] = dig_q[5] + 4'd1;
              end else begin
                dig_d[4] = dig_q[4] + 4'd1;
              end
            end
          end
        end
      end
    end else if (!work_en && set_flag) begin
      // Validate the whole candidate time so an hour digit write cannot form 24..29
      if (set_pos < 3'd6) cand[set_pos] = set_data;
      lim   = (set_pos == 3'd1 || set_pos == 3'd3) ? 4'd5 : 4'd9;
      wr_ok = (set_pos < 3'd6) && (set_data <= lim) && (cand[5] <= 4'd2) &&
              (hour_bin(cand[5], cand[4]) <= 8'd23);
      if (wr_ok) dig_d = cand;
      else       set_err_d = 1'b1;
    end

    hit = tick && alarm_en && (dig_d[1:0] == 8'h00) && (dig_d[5:2] == alarm_q);
    if (alarm_wr) alarm_d = alarm_data;

    if (alarm_ack || !alarm_en) begin
      ring_d     = 1'b0;
      ring_cnt_d = 8'd0;
    end else if (hit) begin
      ring_d     = 1'b1;
      ring_cnt_d = 8'(RING_SECS);
    end else if (ring_q && tick) begin
      ring_cnt_d = ring_cnt_q - 8'd1;
      if (ring_cnt_q == 8'd1) ring_d = 1'b0;
    end

    hour   = hour_bin(dig_d[5], dig_d[4]);
    pm_d   = (hour >= 8'd12);
    data_d = {bin_to_bcd(disp_hour(hour, mode_12h)), dig_d[3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q       <= '0;
      cnt_q       <= '0;
      alarm_q     <= '0;
      ring_q      <= 1'b0;
      ring_cnt_q  <= '0;
      data_q      <= '0;
      pm_q        <= 1'b0;
      sec_pulse_q <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      dig_q       <= dig_d;
      cnt_q       <= cnt_d;
      alarm_q     <= alarm_d;
      ring_q      <= ring_d;
      ring_cnt_q  <= ring_cnt_d;
      data_q      <= data_d;
      pm_q        <= pm_d;
      sec_pulse_q <= sec_pulse_d;
      set_err_q   <= set_err_d;
    end
  end

  assign data      = data_q;
  assign point     = POINT_MASK;
  assign pm        = pm_q;
  assign sec_pulse = sec_pulse_q;
  assign set_err   = set_err_q;
  assign ring      = ring_q;

endmodule

// File: tb/tb_rtc_bcd_core.sv
// Bench for rtc_bcd_core: directed scenarios plus random stimulus against a
// seconds-since-midnight reference model.
module tb_rtc_bcd_core;

  localparam int         TICK_DIV  = 4;
  localparam int         RING_SECS = 3;
  localparam logic [5:0] PMASK     = 6'b101011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        work_en = 1'b0, set_flag = 1'b0, mode_12h = 1'b0;
  logic [2:0]  set_pos = '0;
  logic [3:0]  set_data = '0;
  logic        alarm_wr = 1'b0, alarm_en = 1'b0, alarm_ack = 1'b0;
  logic [15:0] alarm_data = '0;
  logic [23:0] data;
  logic [5:0]  point;
  logic        pm, sec_pulse, set_err, ring;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_secs, m_cnt, m_rc;
  bit          m_ring, m_zero, m_mode;
  logic [15:0] m_alarm;
  logic [23:0] e_data;
  logic        e_pm, e_sp, e_err;

  rtc_bcd_core #(.TICK_DIV(TICK_DIV), .RING_SECS(RING_SECS), .POINT_MASK(PMASK)) dut (
    .clk(clk), .rst(rst), .work_en(work_en), .set_flag(set_flag), .set_pos(set_pos),
    .set_data(set_data), .mode_12h(mode_12h), .alarm_wr(alarm_wr), .alarm_data(alarm_data),
    .alarm_en(alarm_en), .alarm_ack(alarm_ack), .data(data), .point(point), .pm(pm),
    .sec_pulse(sec_pulse), .set_err(set_err), .ring(ring)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [15:0] bcd_hm(input int secs);
    int h  = secs / 3600;
    int mi = (secs / 60) % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10)};
  endfunction

  task automatic try_write(input int pos, input int d);
    int h  = m_secs / 3600;
    int mi = (m_secs / 60) % 60;
    int s  = m_secs % 60;
    int nh;
    bit ok = 1;
    case (pos)
      0: if (d > 9) ok = 0; else s = (s / 10) * 10 + d;
      1: if (d > 5) ok = 0; else s = d * 10 + s % 10;
      2: if (d > 9) ok = 0; else mi = (mi / 10) * 10 + d;
      3: if (d > 5) ok = 0; else mi = d * 10 + mi % 10;
      4: begin nh = (h / 10) * 10 + d; if (d > 9 || nh > 23) ok = 0; else h = nh; end
      5: begin nh = d * 10 + h % 10; if (d > 2 || nh > 23) ok = 0; else h = nh; end
      default: ok = 0;
    endcase
    if (ok) m_secs = h * 3600 + mi * 60 + s;
    else    e_err = 1'b1;
  endtask

  task automatic model();
    bit tick, hit;
    int h, mi, s, dh;
    if (rst) begin
      m_secs = 0; m_cnt = 0; m_alarm = '0; m_ring = 0; m_rc = 0;
      e_sp = 0; e_err = 0; m_zero = 1;
    end else begin
      tick  = work_en && (m_cnt == TICK_DIV - 1);
      hit   = 0;
      e_err = 0;
      m_cnt = (work_en && !tick) ? m_cnt + 1 : 0;
      if (tick) begin
        m_secs = (m_secs + 1) % 86400;
        hit = alarm_en && (m_secs % 60 == 0) && (m_alarm == bcd_hm(m_secs));
      end else if (!work_en && set_flag) begin
        try_write(int'(set_pos), int'(set_data));
      end
      if (alarm_ack || !alarm_en) begin
        m_ring = 0; m_rc = 0;
      end else if (hit) begin
        m_ring = 1; m_rc = RING_SECS;
      end else if (m_ring && tick) begin
        m_rc = m_rc - 1;
        if (m_rc == 0) m_ring = 0;
      end
      e_sp = tick;
      if (alarm_wr) m_alarm = alarm_data;
      m_mode = mode_12h;
      m_zero = 0;
    end
    if (m_zero) begin
      e_data = '0; e_pm = 0;
    end else begin
      h  = m_secs / 3600;
      mi = (m_secs / 60) % 60;
      s  = m_secs % 60;
      dh = !m_mode ? h : (h == 0) ? 12 : (h > 12) ? h - 12 : h;
      e_data = {4'(dh / 10), 4'(dh % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
      e_pm = (h >= 12);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    @(negedge clk);
  endtask

  task automatic set_digit(input int pos, input int d);
    set_flag = 1'b1;
    set_pos  = 3'(pos);
    set_data = 4'(d);
    step();
    set_flag = 1'b0;
  endtask

  task automatic set_time(input int h, input int mi, input int s);
    work_en = 1'b0;
    set_digit(4, 0);
    set_digit(5, h / 10);
    set_digit(4, h % 10);
    set_digit(3, mi / 10);
    set_digit(2, mi % 10);
    set_digit(1, s / 10);
    set_digit(0, s % 10);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (data !== 24'h0) begin errors++; $display("FAIL reset_data got %h exp 000000", data); end
    checks++; if (pm !== 1'b0) begin errors++; $display("FAIL reset_pm got %b exp 0", pm); end
    checks++; if (sec_pulse !== 1'b0) begin errors++; $display("FAIL reset_sec_pulse got %b exp 0", sec_pulse); end
    checks++; if (set_err !== 1'b0) begin errors++; $display("FAIL reset_set_err got %b exp 0", set_err); end
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL reset_ring got %b exp 0", ring); end
    checks++; if (point !== PMASK) begin errors++; $display("FAIL point got %b exp %b", point, PMASK); end
    rst = 1'b0;
  endtask

  task automatic test_rollover();
    mode_12h = 1'b0;
    set_time(23, 59, 58);
    work_en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      checks++; if (sec_pulse !== (i % 4 == 0)) begin errors++; $display("FAIL rollover_pulse cyc %0d got %b exp %b", i, sec_pulse, (i % 4 == 0)); end
      checks++; if (data !== e_data) begin errors++; $display("FAIL rollover_data cyc %0d got %h exp %h", i, data, e_data); end
      if (i == 4) begin
        checks++; if (data !== 24'h235959 || pm !== 1'b1) begin errors++; $display("FAIL rollover_235959 got %h pm %b exp 235959 pm 1", data, pm); end
      end
      if (i == 8) begin
        checks++; if (data !== 24'h000000 || pm !== 1'b0) begin errors++; $display("FAIL rollover_000000 got %h pm %b exp 000000 pm 0", data, pm); end
      end
    end
  endtask

  task automatic test_range();
    mode_12h = 1'b0;
    set_time(15, 30, 20);
    set_digit(1, 6);
    checks++; if (set_err !== 1'b1 || data !== 24'h153020) begin errors++; $display("FAIL range_sh6 got err %b data %h exp 1 153020", set_err, data); end
    step();
    checks++; if (set_err !== 1'b0) begin errors++; $display("FAIL range_err_width got %b exp 0", set_err); end
    set_digit(5, 2);
    checks++; if (set_err !== 1'b1 || data !== 24'h153020) begin errors++; $display("FAIL range_h25 got err %b data %h exp 1 153020", set_err, data); end
    set_digit(6, 1);
    checks++; if (set_err !== 1'b1 || data !== 24'h153020) begin errors++; $display("FAIL range_pos6 got err %b data %h exp 1 153020", set_err, data); end
    set_time(20, 30, 20);
    set_digit(4, 3);
    checks++; if (set_err !== 1'b0 || data[23:16] !== 8'h23) begin errors++; $display("FAIL range_h23 got err %b hour %h exp 0 23", set_err, data[23:16]); end
    // set_flag is ignored while running
    work_en = 1'b1;
    set_digit(0, 12);
    checks++; if (set_err !== 1'b0) begin errors++; $display("FAIL range_ignored got %b exp 0", set_err); end
    work_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      set_digit(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      checks++; if (set_err !== e_err) begin errors++; $display("FAIL range_rand_err got %b exp %b", set_err, e_err); end
      checks++; if (data !== e_data) begin errors++; $display("FAIL range_rand_data got %h exp %h", data, e_data); end
    end
  endtask

  task automatic test_12h();
    mode_12h = 1'b1;
    set_time(0, 15, 0);
    checks++; if (data[23:16] !== 8'h12 || pm !== 1'b0) begin errors++; $display("FAIL h12_midnight got %h pm %b exp 12 pm 0", data[23:16], pm); end
    set_time(13, 0, 0);
    checks++; if (data[23:16] !== 8'h01 || pm !== 1'b1) begin errors++; $display("FAIL h12_13 got %h pm %b exp 01 pm 1", data[23:16], pm); end
    mode_12h = 1'b0;
    checks++; if (data[23:16] !== 8'h01) begin errors++; $display("FAIL h12_latency got %h exp 01", data[23:16]); end
    step();
    checks++; if (data[23:16] !== 8'h13) begin errors++; $display("FAIL h12_back24 got %h exp 13", data[23:16]); end
    for (int i = 0; i < 12; i++) begin
      mode_12h = 1'($urandom_range(0, 1));
      set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), 0);
      checks++; if (data !== e_data || pm !== e_pm) begin errors++; $display("FAIL h12_rand got %h pm %b exp %h pm %b", data, pm, e_data, e_pm); end
    end
    mode_12h = 1'b0;
  endtask

  task automatic test_alarm_timeout();
    int rises = 0, falls = 0;
    logic prev;
    alarm_en = 1'b1;
    alarm_data = 16'h0701;
    alarm_wr = 1'b1;
    step();
    alarm_wr = 1'b0;
    set_time(7, 0, 59);
    work_en = 1'b1;
    prev = ring;
    for (int i = 0; i < 24; i++) begin
      step();
      checks++; if (ring !== m_ring) begin errors++; $display("FAIL alarm_ring cyc %0d got %b exp %b", i, ring, m_ring); end
      if (ring && !prev) begin
        rises++;
        checks++; if (data !== 24'h070100 || sec_pulse !== 1'b1) begin errors++; $display("FAIL alarm_rise got %h pulse %b exp 070100 1", data, sec_pulse); end
      end
      if (!ring && prev) begin
        falls++;
        checks++; if (data !== 24'h070103) begin errors++; $display("FAIL alarm_fall got %h exp 070103", data); end
      end
      prev = ring;
    end
    checks++; if (rises != 1 || falls != 1) begin errors++; $display("FAIL alarm_edges got %0d/%0d exp 1/1", rises, falls); end
  endtask

  task automatic test_alarm_clear();
    int n;
    set_time(7, 0, 59);
    work_en = 1'b1;
    n = 0;
    while (ring !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL clear_no_ring got %b exp 1", ring); end
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL clear_ack got %b exp 0", ring); end
    set_time(7, 0, 59);
    work_en = 1'b1;
    n = 0;
    while (m_cnt != TICK_DIV - 1 && n < 20) begin step(); n++; end
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    checks++; if (ring !== 1'b0 || data !== 24'h070100 || sec_pulse !== 1'b1) begin errors++; $display("FAIL clear_ack_hit got ring %b data %h pulse %b exp 0 070100 1", ring, data, sec_pulse); end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (ring !== 1'b0) begin errors++; $display("FAIL clear_ack_after got %b exp 0", ring); end
    end
    alarm_en = 1'b0;
    set_time(7, 0, 59);
    work_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (ring !== 1'b0) begin errors++; $display("FAIL clear_en0 got %b exp 0", ring); end
    end
    alarm_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    alarm_data = 16'h1235;
    alarm_wr = 1'b1;
    step();
    alarm_wr = 1'b0;
    set_time(12, 34, 56);
    work_en = 1'b1;
    n = 0;
    while (ring !== 1'b1 && n < 40) begin step(); n++; end
    checks++; if (ring !== 1'b1 || data !== 24'h123500) begin errors++; $display("FAIL midrst_ring got %b data %h exp 1 123500", ring, data); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (data !== 24'h0 || pm !== 1'b0 || ring !== 1'b0 || sec_pulse !== 1'b0 || set_err !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got data %h pm %b ring %b pulse %b err %b exp all 0", data, pm, ring, sec_pulse, set_err);
    end
    work_en = 1'b1;
    step(); step();
    work_en = 1'b0;
    step();
    work_en = 1'b1;
    n = 0;
    while (sec_pulse !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (n != TICK_DIV) begin errors++; $display("FAIL reenable_latency got %0d exp %0d", n, TICK_DIV); end
  endtask

  task automatic test_random();
    int nm;
    set_time(11, 58, 40);
    alarm_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      work_en   = ($urandom_range(0, 19) != 0);
      set_flag  = work_en ? ($urandom_range(0, 9) == 0) : 1'($urandom_range(0, 1));
      set_pos   = 3'($urandom_range(0, 7));
      set_data  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) mode_12h = ~mode_12h;
      alarm_wr  = ($urandom_range(0, 29) == 0);
      nm        = ((m_secs / 60) + 1) % 1440;
      alarm_data = ($urandom_range(0, 3) == 0) ? 16'($urandom) : bcd_hm(nm * 60);
      alarm_en  = ($urandom_range(0, 59) != 0);
      alarm_ack = ($urandom_range(0, 79) == 0);
      step();
      checks++; if (data !== e_data) begin errors++; $display("FAIL rand_data cyc %0d got %h exp %h", i, data, e_data); end
      checks++; if (pm !== e_pm) begin errors++; $display("FAIL rand_pm cyc %0d got %b exp %b", i, pm, e_pm); end
      checks++; if (sec_pulse !== e_sp) begin errors++; $display("FAIL rand_pulse cyc %0d got %b exp %b", i, sec_pulse, e_sp); end
      checks++; if (set_err !== e_err) begin errors++; $display("FAIL rand_err cyc %0d got %b exp %b", i, set_err, e_err); end
      checks++; if (ring !== m_ring) begin errors++; $display("FAIL rand_ring cyc %0d got %b exp %b", i, ring, m_ring); end
    end
    set_flag = 1'b0; alarm_wr = 1'b0; alarm_ack = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_rollover();
    test_range();
    test_12h();
    test_alarm_timeout();
    test_alarm_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
